ccip_rd_tag_arbiter: RTL and testbench
======================================

Name: ccip_rd_tag_arbiter

Overview:
- Shares one CCI-P c0 read channel among NUM_INSTANCES compute instances.
- Round-robin arbitration over per-instance read requests. The winning instance's ID is stamped into mdata[15:14] and the request is issued on one registered c0 request port.
- Read responses are steered back to the owning instance by that tag.
- Per-instance outstanding-read credits stop any one instance from monopolising the shared response path. The block sits between the instances' c0 request/response ports and the clock-crossing FIFOs that feed the platform shim.

Parameters:
- NUM_INSTANCES, 4: number of requesters. Legal range 1..4, because the tag is 2 bits.
- MAX_OUTSTANDING, 64: maximum reads in flight per instance.
- HDR_W, 74: c0 request header width; mdata occupies bits [15:0].
- RSP_HDR_W, 28: c0 response header width; mdata occupies bits [15:0].
- CNT_W, $clog2(MAX_OUTSTANDING+1): width of each credit counter.

Ports:
- clk  in  1  block clock
- reset_n  in  1  asynchronous active-low reset
- inst_req_valid  in  NUM_INSTANCES  per-instance read request pending
- inst_req_hdr  in  NUM_INSTANCES*HDR_W  per-instance request header; instance i occupies slice [i*HDR_W +: HDR_W]
- inst_req_ready  out  NUM_INSTANCES  grant; the request is consumed in the same cycle
- out_req_valid  out  1  tagged request to the channel
- out_req_hdr  out  HDR_W  tagged header
- out_almfull  in  1  channel almost-full (c0TxAlmFull)
- rsp_valid  in  1  read response valid
- rsp_hdr  in  RSP_HDR_W  response header
- rsp_data  in  512  response cache line
- inst_rsp_valid  out  NUM_INSTANCES  one-hot response strobe
- inst_rsp_hdr  out  RSP_HDR_W  response header, broadcast to all instances
- inst_rsp_data  out  512  response data, broadcast to all instances
- inst_idle  out  NUM_INSTANCES  instance has zero reads outstanding
- tag_err  out  1  sticky: a response arrived for an instance with zero outstanding reads

Behaviour:
- Reset is asynchronous and active-low. While reset_n = 0:
  - out_req_valid, inst_rsp_valid and tag_err are 0.
  - out_req_hdr, inst_rsp_hdr and inst_rsp_data are 0.
  - All credit counters are 0, so inst_idle is all 1s.
  - The round-robin pointer is 0.
- Eligibility: instance i is eligible when inst_req_valid[i] = 1, count[i] < MAX_OUTSTANDING and out_almfull = 0.
- Arbitration:
  - The search starts at index (last_grant+1) mod NUM_INSTANCES, and the first eligible instance wins.
  - At most one grant per cycle.
  - After reset, last_grant = NUM_INSTANCES-1, so instance 0 has first priority.
  - inst_req_ready is combinational: exactly the one-hot grant, or all zeros.
  - The requester must hold valid and hdr stable until it sees ready.
- Issue:
  - The cycle after a grant to instance i, out_req_valid = 1.
  - out_req_hdr equals the granted header with mdata[15:14] = i[1:0] and mdata[13:0] unchanged.
  - Otherwise out_req_valid = 0 and the header holds its previous value.
  - Request latency is exactly 1 cycle.
- out_almfull: while it is 1, no grants are made. A grant made in the cycle before it rose still issues.
- Response steering:
  - When rsp_valid = 1 with tag t = rsp_hdr[15:14], the next cycle has inst_rsp_valid = one-hot(t).
  - inst_rsp_hdr = rsp_hdr with mdata[15:14] cleared to 0; inst_rsp_data = rsp_data.
  - Response latency is exactly 1 cycle; there is no backpressure on responses.
  - A tag with t >= NUM_INSTANCES: the response is dropped (no strobe) and tag_err is set.
- Credit counters:
  - count[i] increments on a grant to i and decrements on a response tagged i.
  - A grant and a response for the same instance in the same cycle leave the count unchanged.
  - A response for an instance whose count is 0: the response is still forwarded, the count stays at 0 (no wrap) and tag_err is set.
  - A count can never exceed MAX_OUTSTANDING, because eligibility blocks further grants.
- inst_idle[i] = (count[i] == 0), combinational from the registered counters.
- tag_err is cleared only by reset.
- Reset mid-operation: everything returns to reset values. Responses that arrive after reset for reads issued before it set tag_err, which is intended so the host can detect a dirty restart.
- NUM_INSTANCES = 1: the instance is always the arbitration winner when eligible, and the tag is 0.

Test Plan:
- Single request: inst 2 asserts valid with mdata = 0x1234 → ready[2] in the same cycle; next cycle out_req_valid = 1 with mdata = 0x9234. Response with mdata 0x9234 → inst_rsp_valid = 4'b0100 one cycle later, hdr mdata = 0x1234, count[2] back to 0, inst_idle[2] = 1.
- Fairness: all 4 instances hold valid continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3 with 8 back-to-back out_req_valid pulses.
- Credit limit: MAX_OUTSTANDING = 4, inst 0 alone streams requests with no responses → 4 grants, then ready[0] stays 0. One response tagged 0 → exactly one further grant.
- Almost-full: out_almfull = 1 for 5 cycles with all valids high → no grants during those cycles; on release, arbitration resumes from the pointer following the last grant.
- Simultaneous grant and response for inst 1 with count = 3 → count stays 3. A response tagged 3 when count[3] = 0 → strobe 4'b1000 issued, tag_err = 1 and stays 1.
- Asynchronous reset asserted with 2 reads outstanding → outputs clear immediately without a clock. After release, a late response tagged 0 sets tag_err.

Source files
------------

// File: rtl/ccip_rd_tag_arbiter.sv
// Round-robin arbiter sharing one CCI-P c0 read channel among up to four instances.
// Requests are tagged with the instance ID in mdata[15:14]; responses are steered back by that tag.
module ccip_rd_tag_arbiter #(
  parameter int NUM_INSTANCES   = 4,
  parameter int MAX_OUTSTANDING = 64,
  parameter int HDR_W           = 74,
  parameter int RSP_HDR_W       = 28,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_INSTANCES-1:0]       inst_req_valid,
  input  logic [NUM_INSTANCES*HDR_W-1:0] inst_req_hdr,
  output logic [NUM_INSTANCES-1:0]       inst_req_ready,
  output logic                           out_req_valid,
  output logic [HDR_W-1:0]               out_req_hdr,
  input  logic                           out_almfull,
  input  logic                           rsp_valid,
  input  logic [RSP_HDR_W-1:0]           rsp_hdr,
  input  logic [511:0]                   rsp_data,
  output logic [NUM_INSTANCES-1:0]       inst_rsp_valid,
  output logic [RSP_HDR_W-1:0]           inst_rsp_hdr,
  output logic [511:0]                   inst_rsp_data,
  output logic [NUM_INSTANCES-1:0]       inst_idle,
  output logic                           tag_err
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [1:0]       LAST_RST = 2'(NUM_INSTANCES - 1);

  logic [1:0]               last_grant_reg;
  logic [NUM_INSTANCES-1:0] eligible;
  logic [NUM_INSTANCES-1:0] grant;
  logic                     grant_any;
  logic [1:0]               grant_idx;
  int                       arb_idx;
  logic [HDR_W-1:0]         sel_hdr;
  logic [1:0]               rsp_tag;
  logic                     rsp_tag_ok;
  logic [NUM_INSTANCES-1:0] rsp_hit;
  logic [NUM_INSTANCES-1:0] empty_hit;

  assign rsp_tag    = rsp_hdr[15:14];
  assign rsp_tag_ok = int'(rsp_tag) < NUM_INSTANCES;

  for (genvar gi = 0; gi < NUM_INSTANCES; gi++) begin : g_inst
    logic [CNT_W-1:0] count_reg;
    logic             dec;

    assign rsp_hit[gi]   = rsp_valid && (rsp_tag == 2'(gi));
    // A response against an empty counter is forwarded but must not wrap the count.
    assign dec           = rsp_hit[gi] && (count_reg != '0);
    assign empty_hit[gi] = rsp_hit[gi] && (count_reg == '0);
    assign eligible[gi]  = inst_req_valid[gi] && (count_reg < MAX_CNT) && !out_almfull;
    assign inst_idle[gi] = (count_reg == '0);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        count_reg <= '0;
      end else if (grant[gi] && !dec) begin
        count_reg <= count_reg + 1'b1;
      end else if (!grant[gi] && dec) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  // First eligible instance at or after last_grant+1 wins.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    arb_idx   = 0;
    for (int k = 1; k <= NUM_INSTANCES; k++) begin
      arb_idx = (int'(last_grant_reg) + k) % NUM_INSTANCES;
      if (!grant_any && eligible[arb_idx]) begin
        grant[arb_idx] = 1'b1;
        grant_any      = 1'b1;
        grant_idx      = 2'(arb_idx);
      end
    end
  end

  assign inst_req_ready = grant;
  assign sel_hdr        = inst_req_hdr[int'(grant_idx)*HDR_W +: HDR_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_req_valid  <= 1'b0;
      out_req_hdr    <= '0;
      last_grant_reg <= LAST_RST;
    end else begin
      out_req_valid <= grant_any;
      if (grant_any) begin
        out_req_hdr    <= {sel_hdr[HDR_W-1:16], grant_idx, sel_hdr[13:0]};
        last_grant_reg <= grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inst_rsp_valid <= '0;
      inst_rsp_hdr   <= '0;
      inst_rsp_data  <= '0;
      tag_err        <= 1'b0;
    end else begin
      inst_rsp_valid <= rsp_hit;
      if (rsp_valid) begin
        inst_rsp_hdr  <= {rsp_hdr[RSP_HDR_W-1:16], 2'b00, rsp_hdr[13:0]};
        inst_rsp_data <= rsp_data;
      end
      if ((rsp_valid && !rsp_tag_ok) || (|empty_hit)) begin
        tag_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ccip_rd_tag_arbiter.sv
// Self-checking bench for ccip_rd_tag_arbiter: directed scenarios plus a randomized run
// checked against a queue/count-level reference model.
module tb_ccip_rd_tag_arbiter;
  localparam int N    = 4;
  localparam int MAXO = 4;
  localparam int HW   = 74;
  localparam int RW   = 28;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    inst_req_valid = '0;
  logic [N*HW-1:0] inst_req_hdr = '0;
  logic [N-1:0]    inst_req_ready;
  logic            out_req_valid;
  logic [HW-1:0]   out_req_hdr;
  logic            out_almfull = 1'b0;
  logic            rsp_valid = 1'b0;
  logic [RW-1:0]   rsp_hdr = '0;
  logic [511:0]    rsp_data = '0;
  logic [N-1:0]    inst_rsp_valid;
  logic [RW-1:0]   inst_rsp_hdr;
  logic [511:0]    inst_rsp_data;
  logic [N-1:0]    inst_idle;
  logic            tag_err;

  always #5 clk = ~clk;

  ccip_rd_tag_arbiter #(
    .NUM_INSTANCES(N), .MAX_OUTSTANDING(MAXO), .HDR_W(HW), .RSP_HDR_W(RW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .inst_req_valid(inst_req_valid), .inst_req_hdr(inst_req_hdr), .inst_req_ready(inst_req_ready),
    .out_req_valid(out_req_valid), .out_req_hdr(out_req_hdr), .out_almfull(out_almfull),
    .rsp_valid(rsp_valid), .rsp_hdr(rsp_hdr), .rsp_data(rsp_data),
    .inst_rsp_valid(inst_rsp_valid), .inst_rsp_hdr(inst_rsp_hdr), .inst_rsp_data(inst_rsp_data),
    .inst_idle(inst_idle), .tag_err(tag_err)
  );

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // Reference model: outstanding reads per instance, last winner, sticky error.
  int            m_cnt [N];
  int            m_last;
  bit            m_err;
  logic [N-1:0]  exp_ready;
  int            exp_g;
  logic          exp_out_valid;
  logic [HW-1:0] exp_out_hdr;
  logic [N-1:0]  exp_rsp_valid;
  logic [RW-1:0] exp_rsp_hdr;
  logic [511:0]  exp_rsp_data;

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom();
    return l;
  endfunction

  function automatic logic [HW-1:0] rand_hdr(input logic [15:0] mdata);
    logic [95:0]   r;
    logic [HW-1:0] h;
    r = {$urandom(), $urandom(), $urandom()};
    h = r[HW-1:0];
    h[15:0] = mdata;
    return h;
  endfunction

  function automatic logic [RW-1:0] rand_rsp_hdr(input logic [15:0] mdata);
    logic [31:0]   r;
    logic [RW-1:0] h;
    r = $urandom();
    h = r[RW-1:0];
    h[15:0] = mdata;
    return h;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_last = N - 1;
    m_err  = 1'b0;
    exp_g  = -1;
    exp_ready = '0;
    exp_out_valid = 1'b0;
    exp_out_hdr   = '0;
    exp_rsp_valid = '0;
    exp_rsp_hdr   = '0;
    exp_rsp_data  = '0;
  endtask

  task automatic model_eval();
    exp_ready = '0;
    exp_g     = -1;
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (m_last + k) % N;
      if (exp_g < 0 && inst_req_valid[idx] && m_cnt[idx] < MAXO && !out_almfull) begin
        exp_g = idx;
        exp_ready[idx] = 1'b1;
      end
    end
  endtask

  // Apply the current cycle's inputs to the model, then clock once.
  task automatic advance();
    #1;
    model_eval();
    exp_rsp_valid = '0;
    if (rsp_valid) begin
      int t;
      t = int'(rsp_hdr[15:14]);
      exp_rsp_hdr = rsp_hdr;
      exp_rsp_hdr[15:14] = 2'b00;
      exp_rsp_data = rsp_data;
      if (t < N) begin
        exp_rsp_valid[t] = 1'b1;
        if (m_cnt[t] == 0) m_err = 1'b1;
        else m_cnt[t] = m_cnt[t] - 1;
      end else begin
        m_err = 1'b1;
      end
      $display("[%0t] response tag %0d mdata %h", $time, t, rsp_hdr[15:0]);
    end
    exp_out_valid = (exp_g >= 0);
    if (exp_g >= 0) begin
      exp_out_hdr = inst_req_hdr[exp_g*HW +: HW];
      exp_out_hdr[15:14] = 2'(exp_g);
      m_cnt[exp_g] = m_cnt[exp_g] + 1;
      m_last = exp_g;
      $display("[%0t] grant inst %0d mdata %h", $time, exp_g, exp_out_hdr[15:0]);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    inst_req_valid = '0;
    out_almfull = 1'b0;
    rsp_valid = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    assert_cnt++; if (out_req_valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_out_valid: got %b expected 0", out_req_valid); end
    assert_cnt++; if (out_req_hdr !== '0) begin fail_cnt++; $display("FAIL reset_out_hdr: got %h expected 0", out_req_hdr); end
    assert_cnt++; if (inst_rsp_valid !== 4'b0000) begin fail_cnt++; $display("FAIL reset_rsp_valid: got %b expected 0000", inst_rsp_valid); end
    assert_cnt++; if (inst_rsp_hdr !== '0 || inst_rsp_data !== '0) begin fail_cnt++; $display("FAIL reset_rsp_payload: got hdr %h expected 0", inst_rsp_hdr); end
    assert_cnt++; if (tag_err !== 1'b0) begin fail_cnt++; $display("FAIL reset_tag_err: got %b expected 0", tag_err); end
    assert_cnt++; if (inst_idle !== 4'b1111) begin fail_cnt++; $display("FAIL reset_idle: got %b expected 1111", inst_idle); end
    do_reset();
  endtask

  task automatic test_single();
    logic [HW-1:0]  h;
    logic [511:0]   d;
    logic [RW-1:0]  rh;
    h = rand_hdr(16'h1234);
    inst_req_hdr[2*HW +: HW] = h;
    inst_req_valid = 4'b0100;
    #1;
    assert_cnt++; if (inst_req_ready !== 4'b0100) begin fail_cnt++; $display("FAIL single_ready: got %b expected 0100", inst_req_ready); end
    advance();
    inst_req_valid = '0;
    assert_cnt++; if (out_req_valid !== 1'b1) begin fail_cnt++; $display("FAIL single_out_valid: got %b expected 1", out_req_valid); end
    assert_cnt++; if (out_req_hdr[15:0] !== 16'h9234 || out_req_hdr[HW-1:16] !== h[HW-1:16]) begin fail_cnt++; $display("FAIL single_out_hdr: got %h expected mdata 9234", out_req_hdr); end
    assert_cnt++; if (inst_idle !== 4'b1011) begin fail_cnt++; $display("FAIL single_busy: got %b expected 1011", inst_idle); end
    rh = rand_rsp_hdr(16'h9234);
    d  = rand_line();
    rsp_hdr = rh; rsp_data = d; rsp_valid = 1'b1;
    advance();
    rsp_valid = 1'b0;
    assert_cnt++; if (inst_rsp_valid !== 4'b0100) begin fail_cnt++; $display("FAIL single_rsp_valid: got %b expected 0100", inst_rsp_valid); end
    assert_cnt++; if (inst_rsp_hdr !== {rh[RW-1:16], 16'h1234}) begin fail_cnt++; $display("FAIL single_rsp_hdr: got %h expected %h", inst_rsp_hdr, {rh[RW-1:16], 16'h1234}); end
    assert_cnt++; if (inst_rsp_data !== d) begin fail_cnt++; $display("FAIL single_rsp_data: got %h expected %h", inst_rsp_data[63:0], d[63:0]); end
    assert_cnt++; if (inst_idle !== 4'b1111 || out_req_valid !== 1'b0) begin fail_cnt++; $display("FAIL single_idle: got idle %b out_valid %b expected 1111 0", inst_idle, out_req_valid); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] one;
    do_reset();
    for (int i = 0; i < N; i++) inst_req_hdr[i*HW +: HW] = rand_hdr(16'($urandom()));
    inst_req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      one = 4'b0001 << (c % 4);
      #1;
      assert_cnt++; if (inst_req_ready !== one) begin fail_cnt++; $display("FAIL fair_ready cyc %0d: got %b expected %b", c, inst_req_ready, one); end
      advance();
      assert_cnt++; if (out_req_valid !== 1'b1 || out_req_hdr !== exp_out_hdr) begin fail_cnt++; $display("FAIL fair_issue cyc %0d: got %b %h expected 1 %h", c, out_req_valid, out_req_hdr, exp_out_hdr); end
    end
    inst_req_valid = '0;
  endtask

  task automatic test_credit_limit();
    int grants;
    do_reset();
    inst_req_hdr[0 +: HW] = rand_hdr(16'h0042);
    inst_req_valid = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      #1;
      assert_cnt++; if (inst_req_ready !== ((c < MAXO) ? 4'b0001 : 4'b0000)) begin fail_cnt++; $display("FAIL credit_ready cyc %0d: got %b expected %b", c, inst_req_ready, (c < MAXO) ? 4'b0001 : 4'b0000); end
      advance();
    end
    grants = 0;
    for (int c = 0; c < 4; c++) begin
      rsp_valid = (c == 0);
      rsp_hdr = rand_rsp_hdr({2'b00, 14'h0042});
      rsp_data = rand_line();
      #1;
      model_eval();
      assert_cnt++; if (inst_req_ready !== exp_ready) begin fail_cnt++; $display("FAIL credit_refill cyc %0d: got %b expected %b", c, inst_req_ready, exp_ready); end
      if (inst_req_ready[0]) grants++;
      advance();
    end
    rsp_valid = 1'b0;
    inst_req_valid = '0;
    assert_cnt++; if (grants != 1) begin fail_cnt++; $display("FAIL credit_refill_count: got %0d expected 1", grants); end
  endtask

  task automatic test_almfull();
    do_reset();
    for (int i = 0; i < N; i++) inst_req_hdr[i*HW +: HW] = rand_hdr(16'($urandom()));
    inst_req_valid = 4'b1111;
    advance();
    advance();
    out_almfull = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      assert_cnt++; if (inst_req_ready !== 4'b0000) begin fail_cnt++; $display("FAIL almfull_ready cyc %0d: got %b expected 0000", c, inst_req_ready); end
      advance();
      assert_cnt++; if (out_req_valid !== exp_out_valid) begin fail_cnt++; $display("FAIL almfull_out_valid cyc %0d: got %b expected %b", c, out_req_valid, exp_out_valid); end
    end
    out_almfull = 1'b0;
    #1;
    assert_cnt++; if (inst_req_ready !== 4'b0100) begin fail_cnt++; $display("FAIL almfull_resume: got %b expected 0100", inst_req_ready); end
    advance();
    inst_req_valid = '0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    inst_req_hdr[1*HW +: HW] = rand_hdr(16'h0777);
    inst_req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) advance();
    rsp_hdr = rand_rsp_hdr({2'b01, 14'h0777});
    rsp_data = rand_line();
    rsp_valid = 1'b1;
    #1;
    assert_cnt++; if (inst_req_ready !== 4'b0010) begin fail_cnt++; $display("FAIL sim_ready: got %b expected 0010", inst_req_ready); end
    advance();
    inst_req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      rsp_hdr = rand_rsp_hdr({2'b01, 14'($urandom())});
      advance();
      if (c == 1) begin
        assert_cnt++; if (inst_idle[1] !== 1'b0) begin fail_cnt++; $display("FAIL sim_count_kept: got idle %b expected 0", inst_idle[1]); end
      end
    end
    rsp_valid = 1'b0;
    assert_cnt++; if (inst_idle[1] !== 1'b1 || tag_err !== 1'b0) begin fail_cnt++; $display("FAIL sim_drain: got idle %b err %b expected 1 0", inst_idle[1], tag_err); end
    rsp_hdr = rand_rsp_hdr({2'b11, 14'h0123});
    rsp_valid = 1'b1;
    advance();
    rsp_valid = 1'b0;
    assert_cnt++; if (inst_rsp_valid !== 4'b1000 || tag_err !== 1'b1) begin fail_cnt++; $display("FAIL empty_rsp: got strobe %b err %b expected 1000 1", inst_rsp_valid, tag_err); end
    advance();
    advance();
    assert_cnt++; if (tag_err !== 1'b1 || inst_rsp_valid !== 4'b0000) begin fail_cnt++; $display("FAIL tag_err_sticky: got err %b strobe %b expected 1 0000", tag_err, inst_rsp_valid); end
  endtask

  task automatic test_async_reset();
    do_reset();
    inst_req_hdr[0 +: HW] = rand_hdr(16'h0abc);
    inst_req_valid = 4'b0001;
    advance();
    advance();
    inst_req_valid = '0;
    assert_cnt++; if (inst_idle[0] !== 1'b0 || out_req_valid !== 1'b1) begin fail_cnt++; $display("FAIL areset_setup: got idle %b out_valid %b expected 0 1", inst_idle[0], out_req_valid); end
    #2;
    reset_n = 1'b0;
    #1;
    assert_cnt++; if (out_req_valid !== 1'b0 || out_req_hdr !== '0 || inst_idle !== 4'b1111) begin fail_cnt++; $display("FAIL areset_clear: got valid %b hdr %h idle %b expected 0 0 1111", out_req_valid, out_req_hdr, inst_idle); end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    rsp_hdr = rand_rsp_hdr({2'b00, 14'h0abc});
    rsp_valid = 1'b1;
    advance();
    rsp_valid = 1'b0;
    assert_cnt++; if (tag_err !== 1'b1 || inst_rsp_valid !== 4'b0001) begin fail_cnt++; $display("FAIL areset_late_rsp: got err %b strobe %b expected 1 0001", tag_err, inst_rsp_valid); end
  endtask

  task automatic test_random();
    logic [N-1:0] pend;
    logic [N-1:0] exp_idle;
    int g;
    do_reset();
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          inst_req_hdr[i*HW +: HW] = rand_hdr(16'($urandom()));
        end
      end
      inst_req_valid = pend;
      out_almfull = ($urandom_range(0, 7) == 0);
      rsp_valid = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        int t;
        t = $urandom_range(0, N - 1);
        if (m_cnt[t] > 0) begin
          rsp_valid = 1'b1;
          rsp_hdr = rand_rsp_hdr({2'(t), 14'($urandom())});
          rsp_data = rand_line();
        end
      end
      #1;
      model_eval();
      assert_cnt++; if (inst_req_ready !== exp_ready) begin fail_cnt++; $display("FAIL rand_ready cyc %0d: got %b expected %b", c, inst_req_ready, exp_ready); end
      g = exp_g;
      advance();
      if (g >= 0) pend[g] = 1'b0;
      for (int i = 0; i < N; i++) exp_idle[i] = (m_cnt[i] == 0);
      assert_cnt++; if (out_req_valid !== exp_out_valid || (exp_out_valid && out_req_hdr !== exp_out_hdr)) begin fail_cnt++; $display("FAIL rand_issue cyc %0d: got %b %h expected %b %h", c, out_req_valid, out_req_hdr, exp_out_valid, exp_out_hdr); end
      assert_cnt++; if (inst_rsp_valid !== exp_rsp_valid) begin fail_cnt++; $display("FAIL rand_rsp_valid cyc %0d: got %b expected %b", c, inst_rsp_valid, exp_rsp_valid); end
      if (exp_rsp_valid != '0) begin
        assert_cnt++; if (inst_rsp_hdr !== exp_rsp_hdr || inst_rsp_data !== exp_rsp_data) begin fail_cnt++; $display("FAIL rand_rsp_payload cyc %0d: got %h expected %h", c, inst_rsp_hdr, exp_rsp_hdr); end
      end
      assert_cnt++; if (inst_idle !== exp_idle || tag_err !== m_err) begin fail_cnt++; $display("FAIL rand_state cyc %0d: got idle %b err %b expected %b %b", c, inst_idle, tag_err, exp_idle, m_err); end
    end
    inst_req_valid = '0;
    rsp_valid = 1'b0;
    out_almfull = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_fairness();
    test_credit_limit();
    test_almfull();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
